// File: rtl/apb_fifo_pkg.sv
// apb_fifo_pkg
// Shared definitions for the APB FIFO master sequencer: the FSM state
// encoding, word-width helpers for the command/response FIFO words, and
// the positions of the single-bit fields inside those words.
//
// Command word (CMD_W = AW+DW+1):  {write, addr[AW-1:0], wdata[DW-1:0]}
// Response word (RSP_W = DW+2):    {timeout, slverr, data[DW-1:0]}
package apb_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Wait-state counter width; the timeout compare uses TIMEOUT[7:0].
  localparam int CNT_W = 8;

  // Single-bit response fields sit directly above the data field.
  localparam int RSP_SLVERR_OFS  = 0;
  localparam int RSP_TIMEOUT_OFS = 1;

  function automatic int cmd_w(input int aw, input int dw);
    return aw + dw + 1;
  endfunction

  function automatic int rsp_w(input int dw);
    return dw + 2;
  endfunction

  function automatic int cmd_write_bit(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int rsp_slverr_bit(input int dw);
    return dw + RSP_SLVERR_OFS;
  endfunction

  function automatic int rsp_timeout_bit(input int dw);
    return dw + RSP_TIMEOUT_OFS;
  endfunction

endpackage

// File: rtl/apb_fifo_master.sv
// apb_fifo_master
// APB3 master that pops one command at a time from a show-ahead command
// FIFO, runs it as a single APB transfer, and pushes one response word
// into the response FIFO. Slave wait states are bounded by TIMEOUT.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   enable            gate for starting new transfers (sampled in IDLE only)
//   cmd_empty         command FIFO empty flag
//   cmd_rdata         command FIFO head word {write, addr, wdata}
//   cmd_read          command FIFO pop (one cycle, combinational)
//   rsp_full          response FIFO full flag (checked in IDLE only)
//   rsp_write         response FIFO push (DONE state)
//   rsp_wdata         response word {timeout, slverr, data}
//   psel, penable,
//   pwrite, paddr,
//   pwdata            APB master outputs
//   prdata, pready,
//   pslverr           APB slave inputs
//   busy              high whenever the FSM is not IDLE
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for enable, a queued command and response room
// SETUP  | APB setup phase (psel=1, penable=0), wait counter cleared
// ACCESS | APB access phase, waiting for pready or the timeout
// DONE   | push the captured response, bus released
module apb_fifo_master
  import apb_fifo_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cmd_empty,
  input  logic [cmd_w(AW,DW)-1:0] cmd_rdata,
  output logic                    cmd_read,
  input  logic                    rsp_full,
  output logic                    rsp_write,
  output logic [rsp_w(DW)-1:0]    rsp_wdata,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [AW-1:0]           paddr,
  output logic [DW-1:0]           pwdata,
  input  logic [DW-1:0]           prdata,
  input  logic                    pready,
  input  logic                    pslverr,
  output logic                    busy
);

  localparam int RSP_W   = rsp_w(DW);
  localparam int WR_BIT  = cmd_write_bit(AW, DW);
  localparam int ERR_BIT = rsp_slverr_bit(DW);
  localparam int TO_BIT  = rsp_timeout_bit(DW);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT);
  localparam logic             TIMEOUT_EN  = (TIMEOUT != 0);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             start;
  logic             ready_hit;
  logic             timeout_hit;
  logic [RSP_W-1:0] rsp_done;
  logic [RSP_W-1:0] rsp_timeout;

  // Reset also blocks the pop so a command is never taken from the FIFO
  // in a cycle whose edge will discard it.
  assign start = (state == IDLE) & enable & ~cmd_empty & ~rsp_full & ~reset;

  // Saturating increment so TIMEOUT=0 (disabled) cannot wrap the counter.
  assign wait_cnt_inc = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + 1'b1;

  // pready has priority: a ready in the cycle the limit is reached completes
  // the transfer normally.
  assign ready_hit   = (state == ACCESS) & pready;
  assign timeout_hit = (state == ACCESS) & ~pready & TIMEOUT_EN
                       & (wait_cnt_inc == TIMEOUT_LIM);

  always_comb begin
    rsp_done                 = '0;
    rsp_done[ERR_BIT]        = pslverr;
    rsp_done[DW-1:0]         = pwrite ? '0 : prdata;
  end

  always_comb begin
    rsp_timeout              = '0;
    rsp_timeout[TO_BIT]      = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (ready_hit || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    cmd_read  = start;
    psel      = (state == SETUP) || (state == ACCESS);
    penable   = (state == ACCESS);
    rsp_write = (state == DONE);
    busy      = (state != IDLE);
  end

  // Transfer registers, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_wdata <= '0;
      wait_cnt  <= '0;
    end else begin
      if (start) begin
        pwrite <= cmd_rdata[WR_BIT];
        paddr  <= cmd_rdata[WR_BIT-1:DW];
        pwdata <= cmd_rdata[DW-1:0];
      end

      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !pready) begin
        wait_cnt <= wait_cnt_inc;
      end

      if (ready_hit) begin
        rsp_wdata <= rsp_done;
      end else if (timeout_hit) begin
        rsp_wdata <= rsp_timeout;
      end
    end
  end

endmodule

// File: tb/tb_apb_fifo_master.sv
// tb_apb_fifo_master
// Directed bench for apb_fifo_master. The bench plays both FIFOs and a
// scripted APB slave; a transaction-level timeline model predicts every
// output each cycle, and literal expectations pin the model's results.
module tb_apb_fifo_master;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int CW = AW + DW + 1;
  localparam int RW = DW + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          cmd_empty;
  logic [CW-1:0] cmd_rdata;
  logic          cmd_read;
  logic          rsp_full;
  logic          rsp_write;
  logic [RW-1:0] rsp_wdata;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;
  logic          busy;

  apb_fifo_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cmd_empty(cmd_empty), .cmd_rdata(cmd_rdata), .cmd_read(cmd_read),
    .rsp_full(rsp_full), .rsp_write(rsp_write), .rsp_wdata(rsp_wdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Command FIFO contents and per-transfer slave script (same order).
  logic [CW-1:0] cmdq[$];
  int            s_wait[$];    // low-pready ACCESS cycles before ready; -1 = never
  logic [DW-1:0] s_rdata[$];
  logic          s_err[$];

  bit pop_pend   = 1'b0;
  bit idle_ready = 1'b0;
  bit zero_chk   = 1'b0;

  // Timeline model of the transfer in flight.
  bit            m_act = 1'b0;
  int            m_p   = 0;
  int            m_a   = 0;
  logic [CW-1:0] m_cmd;
  logic [RW-1:0] m_rsp;
  int            tx_n     = 0;
  int            acc_cnt  = 0;
  int            n_access = 0;

  // Event log for the literal expectations.
  int            pops_c[$];
  int            push_c[$];
  int            acc_q[$];
  logic [RW-1:0] push_r[$];
  logic [AW-1:0] last_paddr;
  logic [DW-1:0] last_pwdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic upd_fifo();
    cmd_empty = (cmdq.size() == 0);
    cmd_rdata = cmd_empty ? '0 : cmdq[0];
  endtask

  task automatic push_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int w, input logic [DW-1:0] rd, input logic err);
    cmdq.push_back({wr, addr, wd});
    s_wait.push_back(w);
    s_rdata.push_back(rd);
    s_err.push_back(err);
    upd_fifo();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pop_pend) begin
      void'(cmdq.pop_front());
      pop_pend = 1'b0;
    end
    upd_fifo();
  endtask

  // Slave response, per-cycle comparison and model update.
  always @(negedge clk) begin
    int w;
    int d;
    bit t_o;
    bit e_psel, e_pen, e_rsp, e_busy, e_pop;

    if (psel && penable && tx_n > 0) begin
      w       = s_wait[tx_n-1];
      pready  = (w >= 0) && (acc_cnt == w);
      prdata  = pready ? s_rdata[tx_n-1] : 32'hFFFF_0000;
      pslverr = s_err[tx_n-1];
      acc_cnt++;
      n_access++;
      last_paddr  = paddr;
      last_pwdata = pwdata;
    end else begin
      pready  = idle_ready;
      prdata  = 32'hBAD0_BAD0;
      pslverr = idle_ready;
    end

    e_psel = 1'b0;
    e_pen  = 1'b0;
    e_rsp  = 1'b0;
    e_busy = 1'b0;
    if (m_act) begin
      d      = cyc - m_p;
      e_psel = (d >= 1) && (d <= 1 + m_a);
      e_pen  = (d >= 2) && (d <= 1 + m_a);
      e_rsp  = (d == 2 + m_a);
      e_busy = (d >= 1) && (d <= 2 + m_a);
      if (d >= 3 + m_a) m_act = 1'b0;
    end
    e_pop = !m_act && enable && (cmdq.size() != 0) && !rsp_full && !reset;

    chk("cmd_read",  64'(cmd_read),  64'(e_pop));
    chk("psel",      64'(psel),      64'(e_psel));
    chk("penable",   64'(penable),   64'(e_pen));
    chk("rsp_write", 64'(rsp_write), 64'(e_rsp));
    chk("busy",      64'(busy),      64'(e_busy));
    if (e_psel) begin
      chk("paddr",  64'(paddr),  64'(m_cmd[DW+:AW]));
      chk("pwrite", 64'(pwrite), 64'(m_cmd[CW-1]));
      chk("pwdata", 64'(pwdata), 64'(m_cmd[DW-1:0]));
    end
    if (e_rsp) chk("rsp_wdata", 64'(rsp_wdata), 64'(m_rsp));
    if (zero_chk) begin
      chk("rst_paddr",     64'(paddr),     64'd0);
      chk("rst_pwdata",    64'(pwdata),    64'd0);
      chk("rst_pwrite",    64'(pwrite),    64'd0);
      chk("rst_rsp_wdata", 64'(rsp_wdata), 64'd0);
      zero_chk = 1'b0;
    end

    if (rsp_write) begin
      push_c.push_back(cyc);
      push_r.push_back(rsp_wdata);
      acc_q.push_back(n_access);
    end
    if (cmd_read) pops_c.push_back(cyc);
    pop_pend = cmd_read;

    if (reset) begin
      m_act    = 1'b0;
      zero_chk = 1'b1;
    end else if (e_pop) begin
      m_act = 1'b1;
      m_p   = cyc;
      m_cmd = cmdq[0];
      w     = s_wait[tx_n];
      t_o   = (w < 0) || (w >= TO);
      m_a   = t_o ? TO : w + 1;
      m_rsp = t_o ? {2'b10, 32'h0}
                  : {1'b0, s_err[tx_n], (m_cmd[CW-1] ? 32'h0 : s_rdata[tx_n])};
      tx_n++;
      acc_cnt  = 0;
      n_access = 0;
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    rsp_full = 1'b0;
    pready   = 1'b0;
    prdata   = '0;
    pslverr  = 1'b0;
    upd_fifo();
    step();
    step();
    reset = 1'b0;

    // Write, pready held high (also outside ACCESS, where it is ignored).
    idle_ready = 1'b1;
    enable     = 1'b1;
    push_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    repeat (6) step();
    chk("wr_push_count", 64'(push_c.size()), 64'd1);
    chk("wr_latency",    64'(push_c[0] - pops_c[0]), 64'd3);
    chk("wr_rsp",        64'(push_r[0]), 64'h0);
    chk("wr_paddr",      64'(last_paddr), 64'h0010);
    chk("wr_pwdata",     64'(last_pwdata), 64'hDEADBEEF);
    chk("wr_access",     64'(acc_q[0]), 64'd1);

    // Read with three wait states.
    idle_ready = 1'b0;
    push_cmd(1'b0, 16'h0024, 32'h0BADF00D, 3, 32'h12345678, 1'b0);
    repeat (9) step();
    chk("rd_latency", 64'(push_c[1] - pops_c[1]), 64'd6);
    chk("rd_rsp",     64'(push_r[1]), 64'h0_12345678);
    chk("rd_access",  64'(acc_q[1]), 64'd4);

    // Read with slave error.
    push_cmd(1'b0, 16'h0100, 32'h0, 0, 32'hA5A5A5A5, 1'b1);
    repeat (6) step();
    chk("err_rsp",     64'(push_r[2]), 64'h1_A5A5A5A5);
    chk("err_latency", 64'(push_c[2] - pops_c[2]), 64'd3);

    // Timeout (pslverr held high throughout must not leak), then next command.
    push_cmd(1'b1, 16'h0200, 32'h11111111, -1, 32'h55, 1'b1);
    push_cmd(1'b1, 16'h0204, 32'h22222222, 0, 32'h0, 1'b0);
    repeat (14) step();
    chk("to_rsp",       64'(push_r[3]), 64'h2_00000000);
    chk("to_access",    64'(acc_q[3]), 64'd4);
    chk("to_latency",   64'(push_c[3] - pops_c[3]), 64'd6);
    chk("to_next_pop",  64'(pops_c[4] - push_c[3]), 64'd1);
    chk("to_next_rsp",  64'(push_r[4]), 64'h0);
    chk("to_next_addr", 64'(last_paddr), 64'h0204);

    // Flow control: response FIFO full blocks pops.
    rsp_full = 1'b1;
    push_cmd(1'b0, 16'h0400, 32'h0, 1, 32'hCAFE0001, 1'b0);
    push_cmd(1'b0, 16'h0404, 32'h0, 1, 32'hCAFE0002, 1'b0);
    push_cmd(1'b0, 16'h0408, 32'h0, 1, 32'hCAFE0003, 1'b0);
    repeat (5) step();
    chk("full_queue", 64'(cmdq.size()), 64'd3);
    chk("full_psel",  64'(psel), 64'd0);

    // Release full; drop enable right after the first pop.
    rsp_full = 1'b0;
    step();
    enable = 1'b0;
    repeat (10) step();
    chk("en_low_queue",  64'(cmdq.size()), 64'd2);
    chk("en_low_pushes", 64'(push_c.size()), 64'd6);
    chk("en_low_rsp",    64'(push_r[5]), 64'h0_CAFE0001);
    enable = 1'b1;
    repeat (20) step();
    chk("drain_queue",  64'(cmdq.size()), 64'd0);
    chk("drain_pushes", 64'(push_c.size()), 64'd8);
    chk("drain_rsp",    64'(push_r[7]), 64'h0_CAFE0003);

    // Reset in the middle of ACCESS.
    push_cmd(1'b0, 16'h0300, 32'h0, 5, 32'h00000077, 1'b0);
    push_cmd(1'b0, 16'h0304, 32'h0, 0, 32'h99990000, 1'b0);
    repeat (3) step();
    chk("rst_pre_penable", 64'(penable), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_psel",      64'(psel), 64'd0);
    chk("rst_rsp_write", 64'(rsp_write), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    repeat (8) step();
    chk("rst_pushes",   64'(push_c.size()), 64'd9);
    chk("rst_next_rsp", 64'(push_r[8]), 64'h0_99990000);
    chk("rst_queue",    64'(cmdq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_fifo_master.md
# apb_fifo_master

APB3 master sequencer that drains a command FIFO and pushes one response per transfer into a response FIFO. Sits between two `sync_fifo` instances, command side upstream and response side downstream, in the APB test environment. Issues one APB transfer at a time. Bounds slave wait states with a timeout.

## Interface
Parameters:
- `AW`, default 16: APB address width.
- `DW`, default 32: APB data width.
- `TIMEOUT`, default 16: maximum ACCESS cycles with `pready` low before abort. Range 1..255; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  **synchronous, active-high reset.**
- `enable`  in  1  when low, no new transfer starts; a transfer in flight completes.
- `cmd_empty`  in  1  command FIFO empty flag.
- `cmd_rdata`  in  AW+DW+1  command FIFO head word, show-ahead.
- `cmd_read`  out  1  command FIFO pop.
- `rsp_full`  in  1  response FIFO full flag.
- `rsp_write`  out  1  response FIFO push.
- `rsp_wdata`  out  DW+2  response word.
- `psel`, `penable`, `pwrite`  out  1  APB control.
- `paddr`  out  AW  APB address.
- `pwdata`  out  DW  APB write data.
- `prdata`  in  DW  APB read data.
- `pready`  in  1  APB ready.
- `pslverr`  in  1  APB slave error.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Command word fields:
  - bit [AW+DW] is write.
  - [AW+DW-1:DW] is address.
  - [DW-1:0] is write data.
- Response word fields:
  - bit [DW+1] is timeout.
  - bit [DW] is slverr.
  - [DW-1:0] is `prdata` for reads and 0 for writes.
- FSM has four states: IDLE, SETUP, ACCESS, DONE.
- IDLE → SETUP when `enable & !cmd_empty & !rsp_full`.
  - `cmd_read` is high combinationally for that single cycle.
  - The command fields are registered into `pwrite`, `paddr` and `pwdata` at the same edge.
- SETUP → ACCESS unconditionally.
  - `psel` is 1 and `penable` is 0.
  - The wait counter is cleared.
- ACCESS drives `psel` = `penable` = 1.
  - On `pready`: capture `prdata` (reads only) and `pslverr`, then go to DONE.
  - On `!pready`: the counter increments. When the counter reaches `TIMEOUT` (and `TIMEOUT` is not 0), go to DONE with timeout=1, slverr=0, data=0.
- DONE → IDLE unconditionally.
  - `rsp_write` is 1 and `rsp_wdata` holds the captured response.
  - `psel` and `penable` are 0.
- Room in the response FIFO is checked only in IDLE. Because this block is the sole writer and a full transfer takes ≥4 cycles, the push in DONE never hits a full FIFO. The registered `rsp_full` has settled by the next IDLE.
- `paddr`, `pwrite` and `pwdata` stay stable from SETUP through ACCESS. After that they hold their last values.
- The counter is 8 bits and saturates. The comparison is against `TIMEOUT[7:0]`.

## Timing
- Reset values:
  - state IDLE.
  - `psel`, `penable`, `pwrite`, `paddr`, `pwdata` all 0.
  - `rsp_wdata` 0; `busy` 0; counter 0.
  - `cmd_read` and `rsp_write` are 0 because they decode from IDLE/DONE.
- Reset asserted mid-transfer: IDLE at the next edge and `psel` drops. The popped command is lost and no response is pushed.
- Latency, with a command available at cycle 0 in IDLE:
  - Pop at cycle 0.
  - SETUP at cycle 1, ACCESS at cycle 2.
  - With `pready` in cycle 2+n, DONE (push) at cycle 3+n, IDLE at cycle 4+n.
- Minimum 4 cycles per transfer. There are no back-to-back SETUPs.
- `enable` is sampled only in IDLE. Deassertion mid-transfer has no effect.
- `pready` is ignored outside ACCESS.
- `pslverr` with `pready` on a read: slverr=1 and data=`prdata` as presented.
- Timeout with `TIMEOUT`=N: N ACCESS cycles with `pready` low. If `pready` arrives in the same cycle the counter hits N, `pready` wins and timeout=0.

## Structure
- Package `apb_fifo_pkg` holds:
  - the state encoding (IDLE=0, SETUP=1, ACCESS=2, DONE=3).
  - localparam functions for CMD_W=AW+DW+1 and RSP_W=DW+2.
  - field-position localparams for the write, timeout and slverr bits.
- Single flat module with one FSM plus the wait counter. No sub-module is warranted.

## Test plan
- Write: cmd {1, 0x0010, 0xDEADBEEF}, `pready` held 1 → `psel` in cycles 1–2, `penable` in cycle 2, `paddr`=0x0010, `pwdata`=0xDEADBEEF, push in cycle 3 with `rsp_wdata`=0x0_00000000.
- Read with 3 wait states: cmd {0, 0x0024, x}, `pready` high on the 4th ACCESS cycle with `prdata`=0x12345678 → push {0,0,0x12345678} in cycle 6.
- Slave error: read with `pslverr`=1, `prdata`=0xA5A5A5A5 → response {0,1,0xA5A5A5A5}.
- Timeout: `TIMEOUT`=4, `pready` never asserted → exactly 4 ACCESS cycles, then push {1,0,0}, `psel` low, next command accepted.
- Flow control, first case: 3 commands queued with `rsp_full`=1 → no pop and `psel` stays low.
- Flow control, second case: release `rsp_full` and deassert `enable` after the first pop → the first transfer completes and the second does not start until `enable`=1.
- Reset mid-ACCESS: `reset` for 1 cycle → all outputs at reset values next cycle, no `rsp_write`, and the next queued command is processed normally.
